// File: rtl/score_display_bcd_if.sv
// score_display_bcd_if
//   Bundles the score load request, blink control and display/status
//   outputs of score_display_bcd.
//
//   Handshake: over is a load request. It is accepted only on a rising clk
//   edge where the block is idle (busy=0); requests while busy=1 are
//   ignored, and a level-held over starts a new load on the first idle
//   cycle. valid is a one-cycle completion pulse, coincident with the new
//   display value. There is no back-pressure on valid.
//
//   master modport (driver side): score, over, blink_en out; status in.
//   slave  modport (display block): score, over, blink_en in; status out.
//   state_dbg mirrors the controller state (0 IDLE, 1 CONVERT, 2 UPDATE).
interface score_display_bcd_if #(
    parameter int SCORE_W     = 7,
    parameter int NO_DIGITS   = 2,
    parameter int NO_SEGMENTS = 8
) ();
    logic [SCORE_W-1:0]               score;
    logic                             over;
    logic                             blink_en;
    logic                             busy;
    logic                             valid;
    logic                             overflow;
    logic [NO_DIGITS*NO_SEGMENTS-1:0] display;
    logic [1:0]                       state_dbg;

    modport master (
        output score, over, blink_en,
        input  busy, valid, overflow, display, state_dbg
    );

    modport slave (
        input  score, over, blink_en,
        output busy, valid, overflow, display, state_dbg
    );
endinterface

// File: rtl/score_display_bcd.sv
// score_display_bcd
//   Converts an unsigned binary score to BCD with a sequential double-dabble
//   (one bit per clock) and drives NO_DIGITS active-low 7-segment digits.
//   Leading zeros can be blanked, out-of-range scores show dashes, and the
//   display can blink with a half-period of BLINK_DIV clocks.
//
//   Ports:
//     clk   - system clock
//     rst_n - asynchronous active-low reset
//     bus   - score_display_bcd_if.slave: score/over/blink_en in;
//             busy/valid/overflow/display/state_dbg out
module score_display_bcd #(
    parameter int SCORE_W     = 7,
    parameter int NO_DIGITS   = 2,
    parameter int NO_SEGMENTS = 8,
    parameter int BLINK_DIV   = 1000000,
    parameter int BLANK_LZ    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    score_display_bcd_if.slave   bus
);
    localparam int BW = 4 * NO_DIGITS;
    localparam int DW = NO_DIGITS * NO_SEGMENTS;
    localparam int CW = $clog2(SCORE_W + 1);
    localparam int KW = $clog2(BLINK_DIV + 1);
    localparam longint unsigned LIMIT = longint'(10) ** NO_DIGITS;

    localparam logic [NO_SEGMENTS-1:0] SEG_OFF  = '1;
    localparam logic [NO_SEGMENTS-1:0] SEG_DASH = NO_SEGMENTS'(8'hBF);
    localparam logic [NO_SEGMENTS-1:0] SEG_ZERO = NO_SEGMENTS'(8'hC0);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_UPDATE  = 2'd2
    } state_t;

    function automatic logic [NO_SEGMENTS-1:0] seg_code(input logic [3:0] d);
        logic [7:0] c;
        case (d)
            4'd0:    c = 8'hC0;
            4'd1:    c = 8'hF9;
            4'd2:    c = 8'hA4;
            4'd3:    c = 8'hB0;
            4'd4:    c = 8'h99;
            4'd5:    c = 8'h92;
            4'd6:    c = 8'h82;
            4'd7:    c = 8'hF8;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h90;
            default: c = 8'hFF;
        endcase
        return NO_SEGMENTS'(c);
    endfunction

    // Reset shows "0" on digit 0; upper digits follow the blanking mode.
    function automatic logic [DW-1:0] reset_display();
        logic [DW-1:0] r;
        r = '1;
        for (int k = 0; k < NO_DIGITS; k++) begin
            r[k*NO_SEGMENTS +: NO_SEGMENTS] = (k == 0 || BLANK_LZ == 0) ? SEG_ZERO : SEG_OFF;
        end
        return r;
    endfunction

    state_t              state;
    logic [SCORE_W-1:0]  shreg;
    logic [BW-1:0]       bcd;
    logic [BW-1:0]       bcd_adj;
    logic [CW-1:0]       bit_cnt;
    logic                ovf_cap;
    logic [DW-1:0]       held;
    logic [DW-1:0]       next_disp;
    logic                busy_r;
    logic                valid_r;
    logic                overflow_r;
    logic [KW-1:0]       blink_cnt;
    logic                phase_on;
    logic                seen;
    logic [3:0]          nib;

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < NO_DIGITS; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    // Segment image for the finished BCD value. Walk from the top digit down;
    // a digit is blanked while every digit above it (and itself) is zero.
    always_comb begin
        next_disp = '1;
        seen      = 1'b0;
        nib       = '0;
        for (int k = NO_DIGITS - 1; k >= 0; k--) begin
            nib = bcd[4*k +: 4];
            if (ovf_cap) begin
                next_disp[k*NO_SEGMENTS +: NO_SEGMENTS] = SEG_DASH;
            end else if (BLANK_LZ != 0 && !seen && nib == 4'd0 && k != 0) begin
                next_disp[k*NO_SEGMENTS +: NO_SEGMENTS] = SEG_OFF;
            end else begin
                next_disp[k*NO_SEGMENTS +: NO_SEGMENTS] = seg_code(nib);
            end
            if (nib != 4'd0) begin
                seen = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            shreg      <= '0;
            bcd        <= '0;
            bit_cnt    <= '0;
            ovf_cap    <= 1'b0;
            held       <= reset_display();
            busy_r     <= 1'b0;
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.over) begin
                        shreg   <= bus.score;
                        bcd     <= '0;
                        bit_cnt <= '0;
                        ovf_cap <= (64'(bus.score) >= LIMIT);
                        busy_r  <= 1'b1;
                        state   <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    // Bits leaving the top nibble are dropped; only matters
                    // for out-of-range scores, which display dashes anyway.
                    bcd     <= {bcd_adj[BW-2:0], shreg[SCORE_W-1]};
                    shreg   <= shreg << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == CW'(SCORE_W - 1)) begin
                        state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    held       <= next_disp;
                    overflow_r <= ovf_cap;
                    valid_r    <= 1'b1;
                    busy_r     <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Blink phase runs independently of conversions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            phase_on  <= 1'b1;
        end else if (!bus.blink_en) begin
            blink_cnt <= '0;
            phase_on  <= 1'b1;
        end else if (blink_cnt == KW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            phase_on  <= ~phase_on;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign bus.display   = phase_on ? held : '1;
    assign bus.busy      = busy_r;
    assign bus.valid     = valid_r;
    assign bus.overflow  = overflow_r;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_score_display_bcd.sv
module tb_score_display_bcd;
    logic clk;
    logic rst_n;

    score_display_bcd_if #(.SCORE_W(7), .NO_DIGITS(2), .NO_SEGMENTS(8)) m_if ();
    score_display_bcd_if #(.SCORE_W(7), .NO_DIGITS(2), .NO_SEGMENTS(8)) z_if ();
    score_display_bcd_if #(.SCORE_W(7), .NO_DIGITS(2), .NO_SEGMENTS(8)) b_if ();

    score_display_bcd #(.SCORE_W(7), .NO_DIGITS(2), .NO_SEGMENTS(8),
                        .BLINK_DIV(1000000), .BLANK_LZ(1)) dut_m (
        .clk(clk), .rst_n(rst_n), .bus(m_if));
    score_display_bcd #(.SCORE_W(7), .NO_DIGITS(2), .NO_SEGMENTS(8),
                        .BLINK_DIV(1000000), .BLANK_LZ(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .bus(z_if));
    score_display_bcd #(.SCORE_W(7), .NO_DIGITS(2), .NO_SEGMENTS(8),
                        .BLINK_DIV(4), .BLANK_LZ(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(b_if));

    int checks = 0;
    int errors = 0;

    // expected {overflow, display}
    logic [16:0] exp_q[$];
    logic [16:0] zexp_q[$];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // monitors
    always @(negedge clk) begin
        if (rst_n && m_if.valid) begin
            if (exp_q.size() == 0) begin
                check("m_unexpected_valid", 32'(m_if.valid), 32'd0);
            end else begin
                check("m_ovf_display", 32'({m_if.overflow, m_if.display}), 32'(exp_q.pop_front()));
            end
        end
        if (rst_n && z_if.valid) begin
            if (zexp_q.size() == 0) begin
                check("z_unexpected_valid", 32'(z_if.valid), 32'd0);
            end else begin
                check("z_ovf_display", 32'({z_if.overflow, z_if.display}), 32'(zexp_q.pop_front()));
            end
        end
    end

    // drivers
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One-cycle over; checks busy lasts 8 cycles and valid lands at N+8.
    // intrude >= 0 issues an over with score 5 on that busy cycle (ignored).
    task automatic load(input int s, input logic [16:0] exp, input int intrude);
        int busy_cnt;
        @(negedge clk);
        m_if.score = 7'(s);
        m_if.over  = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        m_if.over = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (m_if.busy) busy_cnt++;
            if (i == intrude) begin
                m_if.score = 7'd5;
                m_if.over  = 1'b1;
            end else begin
                m_if.over = 1'b0;
            end
            @(negedge clk);
        end
        m_if.over = 1'b0;
        check("busy_cycles", 32'(busy_cnt), 32'd8);
        check("valid_latency", 32'(m_if.valid), 32'd1);
        check("busy_done", 32'(m_if.busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b1;
        m_if.score = '0; m_if.over = 1'b0; m_if.blink_en = 1'b0;
        z_if.score = '0; z_if.over = 1'b0; z_if.blink_en = 1'b0;
        b_if.score = '0; b_if.over = 1'b0; b_if.blink_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_display", 32'(m_if.display), 32'h0000FFC0);
        check("rst_busy", 32'(m_if.busy), 32'd0);
        check("rst_valid", 32'(m_if.valid), 32'd0);
        check("rst_overflow", 32'(m_if.overflow), 32'd0);
        check("rst_display_nolz", 32'(z_if.display), 32'h0000C0C0);
        check("rst_display_blink", 32'(b_if.display), 32'h0000FFC0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        load(10,  17'h0F9C0, -1);
        load(7,   17'h0FFF8, -1);
        load(0,   17'h0FFC0, -1);
        load(99,  17'h09090, -1);
        load(100, 17'h1BFBF, -1);
        check("ovf_held", 32'(m_if.overflow), 32'd1);
        load(42,  17'h099A4, 2);
        idle(12);
        check("intrude_ignored", 32'(exp_q.size()), 32'd0);
        check("hold_42", 32'({m_if.overflow, m_if.display}), 32'h099A4);

        // level-held over: two back-to-back conversions
        exp_q.push_back(17'h0FFB0);
        exp_q.push_back(17'h0FFB0);
        m_if.score = 7'd3;
        m_if.over  = 1'b1;
        idle(12);
        m_if.over  = 1'b0;
        idle(20);
        check("level_restart", 32'(exp_q.size()), 32'd0);

        load(127, 17'h1BFBF, -1);

        // reset in the middle of CONVERT: no valid, reset display
        @(negedge clk);
        m_if.score = 7'd55;
        m_if.over  = 1'b1;
        @(negedge clk);
        m_if.over  = 1'b0;
        idle(2);
        check("mid_busy", 32'(m_if.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_display", 32'(m_if.display), 32'h0000FFC0);
        check("mid_rst_busy", 32'(m_if.busy), 32'd0);
        check("mid_rst_overflow", 32'(m_if.overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        check("mid_rst_no_update", 32'(m_if.display), 32'h0000FFC0);

        // no leading-zero blanking
        @(negedge clk);
        z_if.score = 7'd7;
        z_if.over  = 1'b1;
        zexp_q.push_back(17'h0C0F8);
        @(negedge clk);
        z_if.over = 1'b0;
        idle(12);
        check("z_done", 32'(zexp_q.size()), 32'd0);

        // blink with BLINK_DIV=4
        b_if.blink_en = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            check($sformatf("blink_k%0d", k), 32'(b_if.display),
                  (((k / 4) % 2) == 0) ? 32'h0000FFC0 : 32'h0000FFFF);
        end
        b_if.blink_en = 1'b0;
        @(negedge clk);
        check("blink_off_show", 32'(b_if.display), 32'h0000FFC0);

        idle(3);
        check("m_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
